// File: rtl/router_pkt_reg.sv
// Packet register stage for a router: accepts header/payload/parity bytes, forwards them to the
// destination FIFO through a skid buffer and checks parity. Define ROUTER_PKT_REG_LEN_CHK_EN for payload length checking.
module router_pkt_reg #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 2,
  parameter int NUM_CH     = 3,
  parameter int SKID_DEPTH = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_rst,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  output logic              busy,
  output logic [DATA_W-1:0] dout,
  output logic              write_enb,
  output logic [ADDR_W-1:0] dest,
  output logic              parity_done,
  output logic              err,
  output logic              len_err,
  output logic              drop
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LFD, S_LOAD, S_DRAIN, S_CHK, S_DROP
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] skid_q [SKID_DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hdr_q, par_q, pkt_par_q, dout_q;
  logic [ADDR_W-1:0] dest_q;
  logic              wv_q, drop_q;

  logic busy_w, accept, skid_empty, hdr_ok;
  logic push, pop, direct, hdr_ld, pay_acc, par_acc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign busy_w = (state_q == S_LFD) || (state_q == S_DRAIN) || (state_q == S_CHK) ||
                  ((state_q == S_LOAD) && (cnt_q == CNT_W'(SKID_DEPTH)));
  assign accept = !busy_w && (((state_q == S_IDLE) && pkt_valid) ||
                              (state_q == S_LOAD) || (state_q == S_DROP));
  assign skid_empty = (cnt_q == '0);
  assign hdr_ok     = ({1'b0, data_in[ADDR_W-1:0]} < (ADDR_W+1)'(NUM_CH));
  assign pay_acc    = accept && (state_q == S_LOAD) && pkt_valid;
  assign par_acc    = accept && (state_q == S_LOAD) && !pkt_valid;
  assign direct     = pay_acc && !fifo_full && skid_empty;
  assign push       = pay_acc && !(!fifo_full && skid_empty) && !soft_rst;
  assign pop        = !fifo_full && !skid_empty && !soft_rst &&
                      ((state_q == S_LOAD) || (state_q == S_DRAIN));
  assign hdr_ld     = (state_q == S_LFD) && !fifo_full;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (soft_rst) cnt_d = '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = hdr_ok ? S_LFD : S_DROP;
      S_LFD:   if (!fifo_full) state_d = S_LOAD;
      S_LOAD:  if (par_acc) state_d = (cnt_d != '0) ? S_DRAIN : S_CHK;
      S_DRAIN: if (cnt_d == '0) state_d = S_CHK;
      S_CHK:   state_d = S_IDLE;
      S_DROP:  if (accept && !pkt_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (soft_rst) state_d = S_IDLE;
  end

  // The output stage holds a byte while the FIFO is full, so write_enb never meets fifo_full=1;
  // every load happens with fifo_full=0, so the stage is always free when reloaded.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      wv_q      <= 1'b0;
      dout_q    <= '0;
      dest_q    <= '0;
      hdr_q     <= '0;
      par_q     <= '0;
      pkt_par_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= !soft_rst && accept && (state_q == S_IDLE) && !hdr_ok;
      if (soft_rst) begin
        head_q    <= '0;
        tail_q    <= '0;
        wv_q      <= 1'b0;
        par_q     <= '0;
        pkt_par_q <= '0;
      end else begin
        if (pop)  head_q <= ptr_inc(head_q);
        if (push) tail_q <= ptr_inc(tail_q);
        if (hdr_ld) begin
          dout_q <= hdr_q;
          wv_q   <= 1'b1;
        end else if (pop) begin
          dout_q <= skid_q[head_q];
          wv_q   <= 1'b1;
        end else if (direct) begin
          dout_q <= data_in;
          wv_q   <= 1'b1;
        end else if (!fifo_full) begin
          wv_q   <= 1'b0;
        end
        if (accept && (state_q == S_IDLE) && hdr_ok) begin
          hdr_q  <= data_in;
          dest_q <= data_in[ADDR_W-1:0];
          par_q  <= data_in;
        end
        if (pay_acc) par_q     <= par_q ^ data_in;
        if (par_acc) pkt_par_q <= data_in;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) skid_q[tail_q] <= data_in;
  end

  assign busy        = busy_w;
  assign dout        = dout_q;
  assign write_enb   = wv_q && !fifo_full && !soft_rst && resetn;
  assign dest        = dest_q;
  assign parity_done = (state_q == S_CHK) && !soft_rst;
  assign err         = parity_done && (par_q != pkt_par_q);
  assign drop        = drop_q;

`ifdef ROUTER_PKT_REG_LEN_CHK_EN
  logic [DATA_W-ADDR_W-1:0] len_q;

  always_ff @(posedge clock) begin
    if (!resetn || soft_rst) begin
      len_q <= '0;
    end else if (accept && (state_q == S_IDLE)) begin
      len_q <= '0;
    end else if (pay_acc) begin
      len_q <= len_q + (DATA_W-ADDR_W)'(1);
    end
  end

  assign len_err = parity_done && (len_q != hdr_q[DATA_W-1:ADDR_W]);
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_pkt_reg.sv
// Randomized bench for router_pkt_reg with a packet-level scoreboard of expected FIFO writes,
// parity/length verdicts and drops.
module tb_router_pkt_reg;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       soft_rst = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [7:0] data_in = '0;
  logic       fifo_full = 1'b0;
  logic       busy, write_enb, parity_done, err, len_err, drop;
  logic [7:0] dout;
  logic [1:0] dest;

  router_pkt_reg #(.DATA_W(8), .ADDR_W(2), .NUM_CH(3), .SKID_DEPTH(2)) dut (
    .clock(clock), .resetn(resetn), .soft_rst(soft_rst), .pkt_valid(pkt_valid),
    .data_in(data_in), .fifo_full(fifo_full), .busy(busy), .dout(dout),
    .write_enb(write_enb), .dest(dest), .parity_done(parity_done), .err(err),
    .len_err(len_err), .drop(drop)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: the driver only appends, the monitor only advances its read indices.
  logic [7:0] exp_wr[$];
  logic [1:0] exp_chk[$];
  int wr_idx = 0, ck_idx = 0, drops_exp = 0, drops_seen = 0;

  int cyc = 0;
  int burst_start = -100;
  int ff_pct = 0;
  int stalls = 0;
  logic [7:0] pl[16];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock)
    fifo_full = ((cyc >= burst_start) && (cyc < burst_start + 4)) ||
                (int'($urandom_range(0, 99)) < ff_pct);

  always @(negedge clock) begin
    #2;
    if (write_enb) begin
      chk("wr_full", {31'd0, fifo_full}, 0);
      chk("wr_avail", {31'd0, wr_idx < exp_wr.size()}, 1);
      if (wr_idx < exp_wr.size()) begin
        chk("wr_data", {24'd0, dout}, {24'd0, exp_wr[wr_idx]});
        wr_idx++;
      end
    end
    if (parity_done) begin
      chk("chk_avail", {31'd0, ck_idx < exp_chk.size()}, 1);
      if (ck_idx < exp_chk.size()) begin
        chk("err", {31'd0, err}, {31'd0, exp_chk[ck_idx][1]});
        chk("len_err", {31'd0, len_err}, {31'd0, exp_chk[ck_idx][0]});
        ck_idx++;
      end
    end
    if (drop) begin
      drops_seen++;
      chk("drop_avail", {31'd0, drops_seen <= drops_exp}, 1);
    end
  end

  // Present one byte until the DUT takes it (busy low at the following edge).
  task automatic present(input logic [7:0] b, input logic pv, input bit is_pay);
    int n = 0;
    bit done = 0;
    while (!done) begin
      @(negedge clock);
      data_in = b;
      pkt_valid = pv;
      #2;
      if (!busy) done = 1;
      else begin
        n++;
        if (is_pay) stalls++;
        if (n > 300) begin
          chk("accept_timeout", n, 0);
          done = 1;
        end
      end
    end
  endtask

  // abort: 0 none, 1 soft_rst, 2 resetn, each after the 2nd payload byte.
  task automatic send_pkt(input logic [7:0] hdr, input int plen, input logic [7:0] par,
                          input int abort, input bit burst);
    logic [7:0] calc;
    bit valid;
    valid = (hdr[1:0] < 2'd3);
    calc = hdr;
    for (int i = 0; i < plen; i++) calc = calc ^ pl[i];
    if (!valid) drops_exp++;
    else if (abort != 0) begin
      exp_wr.push_back(hdr);
      exp_wr.push_back(pl[0]);
    end else begin
      exp_wr.push_back(hdr);
      for (int i = 0; i < plen; i++) exp_wr.push_back(pl[i]);
`ifdef ROUTER_PKT_REG_LEN_CHK_EN
      exp_chk.push_back({calc != par, 32'(plen) != 32'(hdr[7:2])});
`else
      exp_chk.push_back({calc != par, 1'b0});
`endif
    end
    present(hdr, 1'b1, 1'b0);
    if (burst) burst_start = cyc + 2;
    for (int i = 0; i < plen; i++) begin
      present(pl[i], 1'b1, 1'b1);
      if (abort != 0 && i == 1) begin
        @(negedge clock);
        data_in = pl[2];
        if (abort == 1) soft_rst = 1'b1; else resetn = 1'b0;
        @(negedge clock);
        soft_rst = 1'b0;
        resetn = 1'b1;
        pkt_valid = 1'b0;
        #2;
        chk(abort == 1 ? "abort_soft_busy" : "abort_rst_busy", {31'd0, busy}, 0);
        return;
      end
    end
    present(par, 1'b0, 1'b0);
    @(negedge clock);
    pkt_valid = 1'b0;
  endtask

  task automatic set_pl3();
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
  endtask

  initial begin
    int plen, lf;
    logic [7:0] hdr, par;
    logic [1:0] addr;

    repeat (3) @(negedge clock);
    #2;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_wr", {31'd0, write_enb}, 0);
    chk("rst_dout", {24'd0, dout}, 0);
    chk("rst_dest", {30'd0, dest}, 0);
    chk("rst_pdone", {31'd0, parity_done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_len_err", {31'd0, len_err}, 0);
    chk("rst_drop", {31'd0, drop}, 0);
    @(negedge clock);
    resetn = 1'b1;

    set_pl3();
    send_pkt(8'h0D, 3, 8'h0D, 0, 0);
    chk("dest", {30'd0, dest}, 1);
    set_pl3();
    send_pkt(8'h0D, 3, 8'h0C, 0, 0);
    set_pl3();
    stalls = 0;
    send_pkt(8'h0D, 3, 8'h0D, 0, 1);
    chk("busy_skid_full", {31'd0, stalls > 0}, 1);
    set_pl3();
    send_pkt(8'h07, 3, 8'h00, 0, 0);
    set_pl3();
    send_pkt(8'h0E, 3, 8'h0E, 0, 0);
    chk("dest_after_drop", {30'd0, dest}, 2);
    set_pl3();
    send_pkt(8'h11, 3, 8'h11, 0, 0);
    set_pl3();
    send_pkt(8'h0D, 3, 8'h0D, 1, 0);
    set_pl3();
    send_pkt(8'h0D, 3, 8'h0D, 2, 0);
    set_pl3();
    send_pkt(8'h0D, 3, 8'h0D, 0, 0);

    for (int k = 0; k < 40; k++) begin
      ff_pct = (k % 3) * 30;
      plen = $urandom_range(1, 6);
      addr = 2'($urandom_range(0, 3));
      lf = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : plen;
      hdr = {6'(lf), addr};
      par = hdr;
      for (int i = 0; i < plen; i++) begin
        pl[i] = 8'($urandom);
        par = par ^ pl[i];
      end
      if ($urandom_range(0, 3) == 0) par = par ^ 8'(1 << $urandom_range(0, 7));
      send_pkt(hdr, plen, par, 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    ff_pct = 0;

    for (int n = 0; n < 1000; n++) begin
      if (wr_idx == exp_wr.size() && ck_idx == exp_chk.size() && drops_seen == drops_exp) break;
      @(negedge clock);
    end
    repeat (5) @(negedge clock);
    chk("wr_drained", wr_idx, exp_wr.size());
    chk("chk_drained", ck_idx, exp_chk.size());
    chk("drops", drops_seen, drops_exp);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/router_pkt_reg.md
ROUTER_PKT_REG -- requirements
Module: router_pkt_reg

Interface
REQ-001 Parameter DATA_W, default 8, data/header/parity width (>= ADDR_W+2).
REQ-002 Parameter ADDR_W, default 2, header destination field width, header[ADDR_W-1:0].
REQ-003 Parameter NUM_CH, default 3, number of valid destinations (1..2^ADDR_W).
REQ-004 Parameter SKID_DEPTH, default 2, skid buffer entries (>= 1).
REQ-005 Reset resetn, synchronous, active-low; clock clock.
REQ-006 clock  in  1  rising-edge clock.
REQ-007 resetn  in  1  synchronous active-low reset.
REQ-008 soft_rst  in  1  synchronous packet abort.
REQ-009 pkt_valid  in  1  high for header and payload bytes, low for the parity byte.
REQ-010 data_in  in  DATA_W  header, payload or parity byte.
REQ-011 fifo_full  in  1  full flag of the selected destination FIFO.
REQ-012 busy  out  1  source shall not present a byte while high.
REQ-013 dout  out  DATA_W  byte to destination FIFO.
REQ-014 write_enb  out  1  dout valid, FIFO write strobe.
REQ-015 dest  out  ADDR_W  destination of the current packet.
REQ-016 parity_done  out  1  packet check complete.
REQ-017 err  out  1  parity mismatch.
REQ-018 len_err  out  1  payload length mismatch.
REQ-019 drop  out  1  packet discarded, invalid address.

Function
REQ-020 FSM states: IDLE, LFD, LOAD, DRAIN, CHK, DROP.
REQ-021 Accept: a byte is accepted on a rising edge where busy=0 and the FSM is in IDLE with pkt_valid=1, or in LOAD or DROP.
REQ-022 IDLE, accepted header with address < NUM_CH: latch header and dest, set internal parity to header, go to LFD.
REQ-023 IDLE, accepted header with address >= NUM_CH: pulse drop for 1 cycle, go to DROP; no write_enb for that packet.
REQ-024 DROP: ignore bytes; on an accepted byte with pkt_valid=0, go to IDLE.
REQ-025 LFD: when fifo_full=0, dout<=header, write_enb=1 for 1 cycle, go to LOAD; otherwise wait in LFD.
REQ-026 LOAD, accepted byte with pkt_valid=1:
- XOR into internal parity.
- If fifo_full=0 and skid empty: dout<=byte with write_enb the next cycle (1-cycle latency).
- Otherwise: push to skid tail.
REQ-027 Skid drain: each cycle with fifo_full=0 and skid non-empty, pop head to dout with write_enb=1.
- Push and pop on the same edge are allowed.
- Order is strictly FIFO.
REQ-028 LOAD, accepted byte with pkt_valid=0: latch as packet parity; never written.
- Go to DRAIN if skid non-empty, else CHK.
REQ-029 DRAIN: drain per REQ-027; go to CHK on the cycle the skid becomes empty.
REQ-030 CHK lasts exactly 1 cycle, then IDLE.
- parity_done=1 only while in CHK.
- err=1 in CHK iff internal parity != packet parity.
REQ-031 busy = 1 in LFD, DRAIN and CHK, and in LOAD when skid count == SKID_DEPTH; busy = 0 otherwise.
- busy is decoded from registered state only, never combinationally from fifo_full.
REQ-032 write_enb shall never assert while fifo_full=1.
REQ-033 The skid buffer shall never overflow or underflow; a push into a full skid is a design error.
REQ-034 soft_rst=1: next state IDLE, skid cleared, parity cleared; no parity_done, err or write_enb that cycle.
- soft_rst overrides all other events.

Reset
REQ-035 resetn=0 at a rising edge: state IDLE, skid empty, parity registers 0.
- Outputs: dout=0, write_enb=0, dest=0, busy=0, parity_done=0, err=0, len_err=0, drop=0.
REQ-036 Reset mid-packet discards the packet with no further writes.

Configuration
REQ-037 Macro ROUTER_PKT_REG_LEN_CHK_EN, when defined:
- Count accepted payload bytes (pkt_valid=1, header excluded).
- In CHK, len_err=1 iff count != header[DATA_W-1:ADDR_W].
REQ-038 Without ROUTER_PKT_REG_LEN_CHK_EN: no counter, len_err tied 0.

Verification (DATA_W=8, ADDR_W=2, NUM_CH=3, SKID_DEPTH=2)
REQ-039 Header 0x0D, payload 11,22,33, parity 0x0D, fifo_full=0 -> dest=1; writes 0D,11,22,33 in order; parity_done 1 cycle with err=0, len_err=0.
REQ-040 Same packet with parity 0x0C -> parity_done with err=1, 4 writes.
REQ-041 Header 0x0D, fifo_full=1 for 4 cycles during payload -> busy rises at skid count 2; no write while full; all 4 bytes written in order; err=0.
REQ-042 Header 0x07 (addr 3) -> drop pulse; no write_enb until parity byte; back to IDLE; next valid packet passes.
REQ-043 Header 0x11 (length 4) with 3 payload bytes and correct parity -> err=0; len_err=1 with macro, 0 without.
REQ-044 soft_rst, then resetn=0, each after the 2nd payload byte -> IDLE, busy=0, no parity_done; next packet passes.
